// File: rtl/crypto1_rollback.sv
// Crypto1 48-bit LFSR rollback engine: undoes STEPS forward LFSR steps, one per clock.
// Optional macro CRYPTO1_ROLLBACK_INPUT_EN adds the INBITS port that feeds per-step input bits into the feedback.
module crypto1_rollback #(
    parameter int STEP_W = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [47:0]       STATE,
    input  logic [STEP_W-1:0] STEPS,
`ifdef CRYPTO1_ROLLBACK_INPUT_EN
    input  logic [2**STEP_W-1:0] INBITS,
`endif
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [47:0]       KEY,
    output logic              BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [STEP_W-1:0] ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next;
    logic [47:0]       r_work;
    logic [STEP_W-1:0] r_count;
    logic              w_accept;
    logic              w_b0;
    logic [47:0]       w_back;

`ifdef CRYPTO1_ROLLBACK_INPUT_EN
    logic [2**STEP_W-1:0] r_inbits;
    logic [STEP_W-1:0]    w_idx;

    assign w_idx = r_count - ONE;
`endif

    // Recovered oldest bit: forward feedback taps shifted down by one, since the
    // register has already moved every surviving bit one place toward bit 0.
    always_comb begin
        w_b0 = r_work[47]
             ^ r_work[4]  ^ r_work[8]  ^ r_work[9]  ^ r_work[11]
             ^ r_work[13] ^ r_work[14] ^ r_work[16] ^ r_work[18]
             ^ r_work[23] ^ r_work[24] ^ r_work[26] ^ r_work[28]
             ^ r_work[34] ^ r_work[38] ^ r_work[40] ^ r_work[41]
             ^ r_work[42];
`ifdef CRYPTO1_ROLLBACK_INPUT_EN
        w_b0 = w_b0 ^ r_inbits[w_idx];
`endif
        w_back = {r_work[46:0], w_b0};
    end

    assign w_accept = IN_VALID && IN_READY;

    always_comb begin
        w_next    = r_state;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        BUSY      = 1'b0;
        unique case (r_state)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    w_next = (STEPS != '0) ? ROLL : HOLD;
                end
            end
            ROLL: begin
                BUSY = 1'b1;
                if (r_count == ONE) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                BUSY      = 1'b1;
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_count <= '0;
`ifdef CRYPTO1_ROLLBACK_INPUT_EN
            r_inbits <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_work  <= STATE;
                r_count <= STEPS;
`ifdef CRYPTO1_ROLLBACK_INPUT_EN
                r_inbits <= INBITS;
`endif
            end else if (r_state == ROLL) begin
                r_work  <= w_back;
                r_count <= r_count - ONE;
            end
        end
    end

    assign KEY = r_work;

endmodule

// File: tb/tb_crypto1_rollback.sv
// Self-checking bench for crypto1_rollback: directed cases plus random round trips
// against a forward-stepping LFSR model.
module tb_crypto1_rollback;

   localparam int STEP_W = 6;
   localparam int TAPS [18] = '{0, 5, 9, 10, 12, 14, 15, 17, 19, 24, 25, 27, 29, 35, 39, 41, 42, 43};

   logic              CLK = 1'b0;
   logic              RESET = 1'b1;
   logic              IN_VALID = 1'b0;
   logic              IN_READY;
   logic [47:0]       STATE = '0;
   logic [STEP_W-1:0] STEPS = '0;
   logic              OUT_VALID;
   logic              OUT_READY = 1'b0;
   logic [47:0]       KEY;
   logic              BUSY;
`ifdef CRYPTO1_ROLLBACK_INPUT_EN
   logic [2**STEP_W-1:0] INBITS = '0;
`endif

   int checks = 0;
   int errors = 0;

   crypto1_rollback #(.STEP_W(STEP_W)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .IN_VALID(IN_VALID),
      .IN_READY(IN_READY),
      .STATE(STATE),
      .STEPS(STEPS),
`ifdef CRYPTO1_ROLLBACK_INPUT_EN
      .INBITS(INBITS),
`endif
      .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY),
      .KEY(KEY),
      .BUSY(BUSY)
   );

   // Free-running clock, 10 time units per cycle
   always #5 CLK = ~CLK;

   // Forward LFSR step straight from the tap list, with an optional input bit
   function automatic logic [47:0] fwdStep(input logic [47:0] s, input logic inb);
      logic fb;
      fb = inb;
      foreach (TAPS[i]) fb = fb ^ s[TAPS[i]];
      return {fb, s[47:1]};
   endfunction

   // Inverse step found by searching the one unknown bit that makes the forward step reproduce r
   function automatic logic [47:0] backStep(input logic [47:0] r, input logic inb);
      logic [47:0] cand;
      cand = {r[46:0], 1'b0};
      if (fwdStep(cand, inb) != r) cand = {r[46:0], 1'b1};
      return cand;
   endfunction

   // Forward step k consumes inb[k], so running k = 0..n-1 produces the state the engine must undo
   function automatic logic [47:0] fwdMany(input logic [47:0] s, input int n, input logic [63:0] inb);
      logic [47:0] x;
      x = s;
      for (int k = 0; k < n; k++) x = fwdStep(x, inb[k]);
      return x;
   endfunction

   function automatic logic [47:0] backMany(input logic [47:0] s, input int n, input logic [63:0] inb);
      logic [47:0] x;
      x = s;
      for (int k = n - 1; k >= 0; k--) x = backStep(x, inb[k]);
      return x;
   endfunction

   // Single comparison point: counts, asserts and reports
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offers one candidate at a negedge and returns at the negedge after the accepting edge
   task automatic applyStimulus(input string tag, input logic [47:0] st, input int steps, input logic [63:0] inb);
      int wait_cnt;
      wait_cnt = 0;
      @(negedge CLK);
      while (!IN_READY && wait_cnt < 200) begin
         @(negedge CLK);
         wait_cnt++;
      end
      checkOutput({tag, "_ready"}, 64'(IN_READY), 64'd1);
      IN_VALID = 1'b1;
      STATE    = st;
      STEPS    = STEP_W'(steps);
`ifdef CRYPTO1_ROLLBACK_INPUT_EN
      INBITS   = inb;
`else
      if (inb != '0) $display("[TB] note: input bits ignored in this build");
`endif
      @(negedge CLK);
      IN_VALID = 1'b0;
      STATE    = 48'hdead_beef_0bad;
   endtask

   // Full transaction: latency, result, stalled hold behaviour and consume handshake
   task automatic runCandidate(input string tag, input logic [47:0] st, input int steps,
                               input logic [63:0] inb, input logic [47:0] expKey, input int hold);
      int lat;
      logic [47:0] held;
      applyStimulus(tag, st, steps, inb);
      if (steps != 0) begin
         checkOutput({tag, "_busy"}, 64'({BUSY, IN_READY, OUT_VALID}), 64'b100);
      end
      lat = 1;
      while (!OUT_VALID && lat <= 100) begin
         @(negedge CLK);
         lat++;
      end
      checkOutput({tag, "_latency"}, 64'(lat), 64'(steps + 1));
      checkOutput({tag, "_key"}, 64'(KEY), 64'(expKey));
      held = KEY;
      for (int h = 0; h < hold; h++) begin
         IN_VALID = 1'b1;
         STATE    = {$urandom, $urandom};
         @(negedge CLK);
         checkOutput($sformatf("%s_hold%0d", tag, h),
                     64'({OUT_VALID, IN_READY, BUSY, (KEY === held)}), 64'b1011);
      end
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      @(negedge CLK);
      OUT_READY = 1'b0;
      checkOutput({tag, "_consumed"}, 64'({OUT_VALID, IN_READY, BUSY}), 64'b010);
   endtask

   // Hard stop in case the sequence below ever stalls
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed then random sequence, ending in the summary line
   initial begin
      logic [47:0] orig;
      logic [47:0] fed;
      logic [63:0] inb;
      int steps;
      logic sawValid;

      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      checkOutput("reset_flags", 64'({IN_READY, OUT_VALID, BUSY}), 64'b100);
      checkOutput("reset_key", 64'(KEY), 64'd0);

      runCandidate("top_bit", 48'h800000000000, 1, 64'd0, 48'h000000000001, 2);
      runCandidate("zero48", 48'h0, 48, 64'd0, 48'h0, 0);
      runCandidate("steps0", 48'h123456789abc, 0, 64'd0, 48'h123456789abc, 1);

      orig = 48'h27568d75631f;
      fed  = fwdMany(orig, 48, 64'd0);
      runCandidate("roundtrip", fed, 48, 64'd0, orig, 10);

      // Reset in the middle of a long roll must drop the candidate silently
      applyStimulus("abort", 48'hfedcba987654, 48, 64'd0);
      sawValid = 1'b0;
      for (int c = 0; c < 19; c++) begin
         sawValid = sawValid | OUT_VALID;
         @(negedge CLK);
      end
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      checkOutput("abort_flags", 64'({IN_READY, OUT_VALID, BUSY}), 64'b100);
      checkOutput("abort_key", 64'(KEY), 64'd0);
      for (int c = 0; c < 40; c++) begin
         sawValid = sawValid | OUT_VALID;
         @(negedge CLK);
      end
      checkOutput("abort_no_result", 64'(sawValid), 64'd0);
      runCandidate("after_abort", 48'h800000000000, 1, 64'd0, 48'h000000000001, 0);

      for (int n = 0; n < 20; n++) begin
         orig  = {$urandom, $urandom};
         steps = (n == 0) ? 63 : int'($urandom_range(0, 63));
`ifdef CRYPTO1_ROLLBACK_INPUT_EN
         inb = {$urandom, $urandom};
`else
         inb = 64'd0;
`endif
         fed = fwdMany(orig, steps, inb);
         runCandidate($sformatf("rand%0d_rt", n), fed, steps, inb, orig, int'($urandom_range(0, 3)));
         if (n < 4) begin
            orig = {$urandom, $urandom};
            runCandidate($sformatf("rand%0d_bk", n), orig, steps, inb, backMany(orig, steps, inb), 0);
         end
      end

`ifdef CRYPTO1_ROLLBACK_INPUT_EN
      runCandidate("inbit0", 48'h0, 1, 64'd1, 48'h000000000001, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
